// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage with an EX/MEM register, a two-state data-memory access FSM and a MEM/WB register.
// Latency : 2 edges from ex_* to wb_* for non-memory ops; a memory op writes back on the edge where dmem_ack is seen.
// Backpr. : stall (combinational) holds upstream and the EX/MEM register while an access waits for dmem_ack.
//
// Ports   : clk, rst_n (async active-low)
//           ex_*           instruction from execute (valid, control bits, zero flag, alu result, store data, target, dest reg)
//           stall          hold upstream stages
//           pc_src         taken-branch redirect, branch_target = redirect address
//           dmem_*         data-memory request (req/we/addr/wdata) and response (rdata/ack)
//           wb_*           write-back outputs (valid, reg_write, write_reg, data)
//           stall_cycles   saturating stall-cycle counter, present only when MEM_STALL_CNT_EN is defined
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_branch,
   input  logic        ex_zero,
   input  logic [15:0] ex_alu_result,
   input  logic [15:0] ex_write_data,
   input  logic [15:0] ex_branch_target,
   input  logic [2:0]  ex_write_reg,
   output logic        stall,
   output logic        pc_src,
   output logic [15:0] branch_target,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [2:0]  wb_write_reg,
   output logic [15:0] wb_data
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic        valid;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
      logic        branch;
      logic        zero;
      logic [15:0] alu_result;
      logic [15:0] write_data;
      logic [15:0] branch_target;
      logic [2:0]  write_reg;
   } mreg_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [2:0]  write_reg;
      logic [15:0] data;
   } wbreg_t;

   state_t state_q, state_d;
   mreg_t  m_q, m_d, ex_in;
   wbreg_t wb_q, wb_d;
   logic   mem_op_in;

`ifdef MEM_STALL_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
`endif

   always_comb begin
      ex_in = '{valid:         ex_valid,
                mem_read:      ex_mem_read,
                mem_write:     ex_mem_write,
                reg_write:     ex_reg_write,
                mem_to_reg:    ex_mem_to_reg,
                branch:        ex_branch,
                zero:          ex_zero,
                alu_result:    ex_alu_result,
                write_data:    ex_write_data,
                branch_target: ex_branch_target,
                write_reg:     ex_write_reg};

      // dmem_ack is only meaningful while an access is outstanding
      stall     = (state_q == ACCESS) && !dmem_ack;
      mem_op_in = ex_valid && (ex_mem_read || ex_mem_write);

      m_d = stall ? m_q : ex_in;

      // The instruction captured on a non-stalled edge decides the next state,
      // so an acked access can chain straight into the next one.
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = mem_op_in ? ACCESS : IDLE;
         ACCESS:  if (dmem_ack) state_d = mem_op_in ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase

      wb_d = wb_q;
      if (stall) begin
         wb_d.valid = 1'b0;
      end else begin
         wb_d.valid     = m_q.valid;
         wb_d.reg_write = m_q.valid & m_q.reg_write;
         wb_d.write_reg = m_q.write_reg;
         wb_d.data      = (m_q.mem_to_reg && state_q == ACCESS) ? dmem_rdata : m_q.alu_result;
      end

`ifdef MEM_STALL_CNT_EN
      stall_cycles_d = stall_cycles_q;
      if (stall && stall_cycles_q != 16'hFFFF) stall_cycles_d = stall_cycles_q + 16'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         wb_q    <= '0;
`ifdef MEM_STALL_CNT_EN
         stall_cycles_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         wb_q    <= wb_d;
`ifdef MEM_STALL_CNT_EN
         stall_cycles_q <= stall_cycles_d;
`endif
      end
   end

   // Request fields come straight from the held EX/MEM register, so they stay
   // stable for the whole access. A write wins when both read and write are set.
   assign dmem_req      = (state_q == ACCESS);
   assign dmem_we       = m_q.mem_write;
   assign dmem_addr     = m_q.alu_result;
   assign dmem_wdata    = m_q.write_data;

   assign pc_src        = m_q.valid & m_q.branch & m_q.zero;
   assign branch_target = m_q.branch_target;

   assign wb_valid      = wb_q.valid;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_write_reg  = wb_q.write_reg;
   assign wb_data       = wb_q.data;

`ifdef MEM_STALL_CNT_EN
   assign stall_cycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : scoreboard bench for mem_stage; queues of expected memory accesses and write-backs.
// Latency : checks exact write-back cycle (2 edges for ALU ops, ack edge + 1 sample for memory ops).
// Backpr. : the bench holds ex_* while its model predicts a stall.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
   logic        ex_mem_to_reg = 1'b0, ex_branch = 1'b0, ex_zero = 1'b0;
   logic [15:0] ex_alu_result = '0, ex_write_data = '0, ex_branch_target = '0;
   logic [2:0]  ex_write_reg = '0;
   logic        stall, pc_src, dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [15:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic        wb_valid, wb_reg_write;
   logic [2:0]  wb_write_reg;
   logic [15:0] wb_data;
`ifdef MEM_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
      .ex_zero(ex_zero), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
      .ex_branch_target(ex_branch_target), .ex_write_reg(ex_write_reg),
      .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data)
`ifdef MEM_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid, mem_read, mem_write, reg_write, mem_to_reg, branch, zero;
      logic [15:0] alu, wdata, target;
      logic [2:0]  wreg;
   } ins_t;

   typedef struct {
      logic [15:0] addr, wdata, rdata;
      logic        we;
      int          lat;
   } mem_t;

   typedef struct {
      logic        rw;
      logic [2:0]  wreg;
      logic [15:0] data;
      bit          is_mem;
      int          cyc;
   } wb_t;

   mem_t mq[$];
   wb_t  wq[$];
   int   ackq[$];
   ins_t cur_m;
   int   stall_model = 0;
   int   cyc = 0;
   int   checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ins_t mk(input logic v, rd, wr, rw, m2r, br, z,
                               input logic [15:0] alu, wd, tgt, input logic [2:0] wreg);
      ins_t i;
      i = '{valid: v, mem_read: rd, mem_write: wr, reg_write: rw, mem_to_reg: m2r, branch: br,
            zero: z, alu: alu, wdata: wd, target: tgt, wreg: wreg};
      return i;
   endfunction

   function automatic ins_t bubble();
      return mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
   endfunction

   // One cycle: present ins, act as data memory, check outputs, and record what
   // the model expects if the instruction is taken on the coming edge.
   task automatic step(input ins_t ins, input int lat, input logic [15:0] rd, output bit cap);
      bit   exp_req, ack, memop;
      mem_t me;
      wb_t  we;
      @(negedge clk);
      cyc++;
      ex_valid = ins.valid;  ex_mem_read = ins.mem_read;  ex_mem_write = ins.mem_write;
      ex_reg_write = ins.reg_write;  ex_mem_to_reg = ins.mem_to_reg;
      ex_branch = ins.branch;  ex_zero = ins.zero;
      ex_alu_result = ins.alu;  ex_write_data = ins.wdata;
      ex_branch_target = ins.target;  ex_write_reg = ins.wreg;

      exp_req = (mq.size() > 0);
      chk("dmem_req", dmem_req, exp_req);
      chk("pc_src", pc_src, cur_m.valid & cur_m.branch & cur_m.zero);
      chk("branch_target", branch_target, cur_m.target);
`ifdef MEM_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, stall_model);
`endif
      if (exp_req) begin
         chk("dmem_addr", dmem_addr, mq[0].addr);
         chk("dmem_we", dmem_we, mq[0].we);
         chk("dmem_wdata", dmem_wdata, mq[0].wdata);
         if (mq[0].lat == 0) begin
            ack = 1'b1;
            dmem_rdata = mq[0].rdata;
            void'(mq.pop_front());
            ackq.push_back(cyc);
         end else begin
            ack = 1'b0;
            dmem_rdata = 16'($urandom);
            mq[0].lat--;
         end
      end else begin
         ack = 1'($urandom_range(0, 1));
         dmem_rdata = 16'($urandom);
      end
      dmem_ack = ack;
      #1;
      chk("stall", stall, exp_req && !ack);
      if (exp_req && !ack && stall_model < 65535) stall_model++;
      cap = !(exp_req && !ack);
      if (cap) begin
         cur_m = ins;
         if (ins.valid) begin
            memop = ins.mem_read | ins.mem_write;
            if (memop) begin
               me.addr = ins.alu;  me.wdata = ins.wdata;  me.rdata = rd;
               me.we = ins.mem_write;  me.lat = lat;
               mq.push_back(me);
            end
            we.rw = ins.reg_write;  we.wreg = ins.wreg;
            we.data = (memop && ins.mem_to_reg) ? rd : ins.alu;
            we.is_mem = memop;  we.cyc = cyc + 2;
            wq.push_back(we);
         end
      end
   endtask

   task automatic issue(input ins_t ins, input int lat, input logic [15:0] rd);
      bit cap = 1'b0;
      int n = 0;
      while (!cap && n < 20) begin
         step(ins, lat, rd, cap);
         n++;
      end
      if (!cap) begin
         errors++;
         $display("FAIL issue_timeout: instruction not accepted after %0d cycles", n);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) issue(bubble(), 0, 16'h0);
   endtask

   task automatic check_reset_state();
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_pc_src", pc_src, 0);
      chk("rst_branch_target", branch_target, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_reg_write", wb_reg_write, 0);
      chk("rst_wb_data", wb_data, 0);
`ifdef MEM_STALL_CNT_EN
      chk("rst_stall_cycles", stall_cycles, 0);
`endif
   endtask

   // Write-back monitor: every wb_valid pulse must match the oldest expected entry, on time.
   initial begin
      wb_t e;
      int  due;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && wb_valid) begin
            if (wq.size() == 0) begin
               chk("wb_spurious", wb_valid, 0);
            end else begin
               e = wq.pop_front();
               due = e.cyc;
               if (e.is_mem) due = (ackq.size() > 0) ? ackq.pop_front() + 1 : -1;
               chk("wb_cycle", cyc, due);
               chk("wb_reg_write", wb_reg_write, e.rw);
               chk("wb_write_reg", wb_write_reg, e.wreg);
               chk("wb_data", wb_data, e.data);
            end
         end
      end
   end

   initial begin
      ins_t r;
      cur_m = '0;
      #2;
      check_reset_state();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU op: write-back two edges later, no stall
      issue(mk(1, 0, 0, 1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 3'd5), 0, 16'h0);
      idle(3);
      // Load with three wait cycles
      issue(mk(1, 1, 0, 1, 1, 0, 0, 16'h0040, 16'h0, 16'h0, 3'd2), 3, 16'hBEEF);
      idle(6);
      // Store immediately followed by a load: back-to-back requests
      issue(mk(1, 0, 1, 0, 0, 0, 0, 16'h0010, 16'h00AA, 16'h0, 3'd1), 1, 16'h5555);
      issue(mk(1, 1, 0, 1, 1, 0, 0, 16'h0012, 16'h0, 16'h0, 3'd3), 0, 16'hC0DE);
      issue(mk(1, 1, 1, 1, 1, 0, 0, 16'h0014, 16'h7777, 16'h0, 3'd4), 2, 16'h1111);
      idle(6);
      // Branch taken, not taken, and invalid
      issue(mk(1, 0, 0, 0, 0, 1, 1, 16'h0, 16'h0, 16'h0100, 3'd0), 0, 16'h0);
      idle(2);
      issue(mk(1, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0100, 3'd0), 0, 16'h0);
      issue(mk(0, 1, 1, 1, 0, 1, 1, 16'h0020, 16'h0, 16'h0100, 3'd6), 0, 16'h0);
      idle(3);

      // Reset in the middle of an access, then a late ack after release
      issue(mk(1, 1, 0, 1, 1, 0, 0, 16'h0080, 16'h0, 16'h0, 3'd7), 6, 16'hDEAD);
      idle(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state();
      mq.delete();  wq.delete();  ackq.delete();
      cur_m = '0;  stall_model = 0;
      r = bubble();
      ex_valid = 1'b0;  ex_mem_read = 1'b0;  ex_mem_write = 1'b0;  ex_branch = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      issue(r, 0, 16'h0);
      issue(r, 0, 16'h0);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         r.valid      = ($urandom_range(0, 9) < 8);
         r.mem_read   = ($urandom_range(0, 9) < 3);
         r.mem_write  = ($urandom_range(0, 9) < 3);
         r.reg_write  = 1'($urandom);
         r.mem_to_reg = 1'($urandom);
         r.branch     = 1'($urandom);
         r.zero       = 1'($urandom);
         r.alu        = 16'($urandom);
         r.wdata      = 16'($urandom);
         r.target     = 16'($urandom);
         r.wreg       = 3'($urandom);
         issue(r, $urandom_range(0, 3), 16'($urandom));
      end
      idle(12);
      chk("wb_queue_drained", wq.size(), 0);
      chk("mem_queue_drained", mq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have the ports: clk in 1, rising-edge clock.
REQ-002 The block SHALL have the ports: rst_n in 1, asynchronous active-low reset.
REQ-003 The block SHALL have the ports: ex_valid in 1, execute stage presents an instruction.
REQ-004 The block SHALL have the ports: ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch in 1 each, control bits from decode.
REQ-005 The block SHALL have the ports: ex_zero in 1, ALU zero flag.
REQ-006 The block SHALL have the ports: ex_alu_result, ex_write_data, ex_branch_target in 16 each, ALU result, store data, branch target.
REQ-007 The block SHALL have the ports: ex_write_reg in 3, destination register.
REQ-008 The block SHALL have the ports: stall out 1, hold upstream stages.
REQ-009 The block SHALL have the ports: pc_src out 1 and branch_target out 16, taken-branch redirect.
REQ-010 The block SHALL have the ports: dmem_req out 1, dmem_we out 1, dmem_addr out 16, dmem_wdata out 16, data-memory request.
REQ-011 The block SHALL have the ports: dmem_rdata in 16, dmem_ack in 1, data-memory response.
REQ-012 The block SHALL have the ports: wb_valid out 1, wb_reg_write out 1, wb_write_reg out 3, wb_data out 16, to write-back.

Function
REQ-013 The EX/MEM register (m_*) SHALL capture all ex_* inputs on each clk edge with stall=0, and SHALL hold its contents with stall=1.
REQ-014 The FSM SHALL have two states: IDLE and ACCESS.
REQ-015 In IDLE, a capture with ex_valid=1 and (ex_mem_read or ex_mem_write) SHALL move the FSM to ACCESS; it SHALL stay in IDLE otherwise.
REQ-016 In ACCESS, the block SHALL drive dmem_req=1, dmem_addr=m_alu_result, dmem_wdata=m_write_data and dmem_we=m_mem_write, all stable until ack.
REQ-017 If both m_mem_read and m_mem_write are set, the block SHALL treat the access as a write (dmem_we=1).
REQ-018 stall SHALL be combinational: stall = (state==ACCESS) and not dmem_ack.
REQ-019 On the edge where ACCESS sees dmem_ack=1, the FSM SHALL return to IDLE, or go back to ACCESS if the newly captured instruction is a memory op; back-to-back accesses SHALL have no idle cycle.
REQ-020 In IDLE, dmem_req SHALL be 0 and dmem_ack SHALL be ignored.
REQ-021 The MEM/WB register SHALL load wb_valid<=0 on each edge with stall=1.
REQ-022 On each edge with stall=0, the MEM/WB register SHALL load wb_valid<=m_valid, wb_reg_write<=m_valid&m_reg_write, wb_write_reg<=m_write_reg.
REQ-023 On the same edges, it SHALL load wb_data<=dmem_rdata when m_mem_to_reg=1 and ACCESS, and m_alu_result otherwise.
REQ-024 Latency SHALL be 2 edges from ex_* to wb_* for a non-memory op, and SHALL be the ack edge for a memory op.
REQ-025 pc_src SHALL equal m_valid & m_branch & m_zero, and branch_target SHALL equal m_branch_target (registered, combinational output).
REQ-026 An instruction with m_valid=0 SHALL cause no memory request, no pc_src and no write-back.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM IDLE, every m_* and wb_* register 0, dmem_req=0, stall=0, pc_src=0, branch_target=0, wb_data=0.
REQ-028 A reset during ACCESS SHALL abort the access; a late dmem_ack after reset release SHALL be ignored.
REQ-029 Release of rst_n SHALL take effect on the next clk edge.

Configuration
REQ-030 With MEM_STALL_CNT_EN defined, the block SHALL add port stall_cycles out 16, which increments once per clk edge with stall=1, saturates at 0xFFFF, and resets to 0.
REQ-031 Without MEM_STALL_CNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-032 ALU op (alu_result=0x1234, reg_write=1, write_reg=5), no memory op -> wb_valid=1, wb_data=0x1234, wb_write_reg=5 two edges later; stall stays 0.
REQ-033 Load from addr 0x0040, ack after 3 cycles with rdata=0xBEEF -> dmem_req=1, we=0 for 3 cycles, stall=1 for 3 cycles, wb_valid=0 during the wait, then wb_data=0xBEEF.
REQ-034 Store (addr 0x0010, data 0x00AA), followed immediately by a load (addr 0x0012) -> two requests back-to-back with no idle cycle; the store gives wb_reg_write=0.
REQ-035 Branch with zero=1, target 0x0100 -> pc_src=1, branch_target=0x0100 for one cycle; the same branch with zero=0, or with ex_valid=0, -> pc_src=0.
REQ-036 rst_n pulled low mid-ACCESS, then ack asserted after release -> dmem_req=0 and stall=0 at once, no write-back, and stall_cycles=0 (macro on).
